// File: rtl/ahb_seg_scanner.sv
// ahb_seg_scanner: zero-wait-state AHB-Lite slave that scans a multiplexed
// seven-segment display of NUM_DIGITS digits. It supports a programmable
// slot length, hex-decode or raw segment content, decimal-point and blanking
// masks, and 16-level brightness PWM. SEG and SEGCS are registered pin outputs.
module ahb_seg_scanner #(
  parameter int          NUM_DIGITS     = 4,
  parameter logic [15:0] DEFAULT_DIV    = 16'd5000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          CS_ACTIVE_LOW  = 1'b1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [7:0]            SEG,
  output logic [NUM_DIGITS-1:0] SEGCS
);

  // Word offsets (HADDR[7:2]).
  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_VALUE  = 6'h01;
  localparam logic [5:0] OFF_DP     = 6'h02;
  localparam logic [5:0] OFF_BLANK  = 6'h03;
  localparam logic [5:0] OFF_RAW0   = 6'h04;
  localparam logic [5:0] OFF_RAW1   = 6'h05;
  localparam logic [5:0] OFF_DIV    = 6'h08;
  localparam logic [5:0] OFF_STATUS = 6'h09;

  // Writable bits per register; bits of absent digits stay zero.
  localparam logic [31:0] CTRL_MASK  = 32'h0000_0F03;
  localparam logic [31:0] DIV_MASK   = 32'h0000_FFFF;
  localparam logic [31:0] DIG_MASK   = (32'h1 << NUM_DIGITS) - 32'h1;
  localparam logic [31:0] VALUE_MASK = (NUM_DIGITS >= 8) ? 32'hFFFF_FFFF
                                     : (32'h1 << (4 * NUM_DIGITS)) - 32'h1;
  localparam logic [31:0] RAW0_MASK  = (NUM_DIGITS >= 4) ? 32'hFFFF_FFFF
                                     : (32'h1 << (8 * NUM_DIGITS)) - 32'h1;
  localparam logic [31:0] RAW1_MASK  = (NUM_DIGITS <= 4) ? 32'h0
                                     : (NUM_DIGITS >= 8) ? 32'hFFFF_FFFF
                                     : (32'h1 << (8 * (NUM_DIGITS - 4))) - 32'h1;
  localparam logic [2:0]  LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [15:0] RESET_PRESC = (DEFAULT_DIV == 16'd0) ? 16'd1 : DEFAULT_DIV;
  localparam logic [7:0]  SEG_OFF    = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] CS_OFF = {NUM_DIGITS{CS_ACTIVE_LOW}};

  // Bus handshake: a transfer is accepted in its address phase when
  // HREADY & HSEL & HTRANS[1]; its data phase is the next cycle, always
  // zero-wait (HREADYOUT=1), and a write commits on the edge ending it.
  logic [5:0]  addr_q;
  logic        wr_q, valid_q;
  logic [3:0]  strb_q, strb;
  logic        we;
  logic [31:0] lanes, rdata;

  logic [31:0] ctrl_q, ctrl_d, value_q, value_d, dp_q, dp_d, blank_q, blank_d;
  logic [31:0] raw0_q, raw0_d, raw1_q, raw1_d, div_q, div_d;

  logic [15:0] presc_q, reload;
  logic [2:0]  idx_q;
  logic        first_q;
  logic [7:0]  frame_q;
  logic [3:0]  pwm_q;
  logic        en_q, en_d;

  logic [3:0]            nib;
  logic [7:0]            raw_byte, digit_seg;
  logic                  sel_on;
  logic [NUM_DIGITS-1:0] cs_hot;
  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] segcs_q;

  logic unused_bits;
  assign unused_bits = ^{HPROT, HADDR[31:8], HTRANS[0]};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [31:0] wl, input logic [31:0] valid);
    return (old & ~(wl & valid)) | (wdata & wl & valid);
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Byte-lane strobes for the transfer currently in its address phase.
  always_comb begin
    case (HSIZE)
      3'b000:  strb = 4'b0001 << HADDR[1:0];
      3'b001:  strb = HADDR[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  // Capture the address phase; hold it while another slave stalls the bus.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= 6'h0; wr_q <= 1'b0; strb_q <= 4'h0; valid_q <= 1'b0;
    end else if (HREADY) begin
      valid_q <= HSEL & HTRANS[1];
      addr_q  <= HADDR[7:2];
      wr_q    <= HWRITE;
      strb_q  <= strb;
    end
  end

  assign we    = valid_q & wr_q & HREADY;
  assign lanes = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};

  // Next register values for a data-phase write; STATUS and holes ignore writes.
  always_comb begin
    ctrl_d = ctrl_q; value_d = value_q; dp_d = dp_q; blank_d = blank_q;
    raw0_d = raw0_q; raw1_d = raw1_q; div_d = div_q;
    if (we) begin
      case (addr_q)
        OFF_CTRL:  ctrl_d  = merge(ctrl_q,  HWDATA, lanes, CTRL_MASK);
        OFF_VALUE: value_d = merge(value_q, HWDATA, lanes, VALUE_MASK);
        OFF_DP:    dp_d    = merge(dp_q,    HWDATA, lanes, DIG_MASK);
        OFF_BLANK: blank_d = merge(blank_q, HWDATA, lanes, DIG_MASK);
        OFF_RAW0:  raw0_d  = merge(raw0_q,  HWDATA, lanes, RAW0_MASK);
        OFF_RAW1:  raw1_d  = merge(raw1_q,  HWDATA, lanes, RAW1_MASK);
        OFF_DIV:   div_d   = merge(div_q,   HWDATA, lanes, DIV_MASK);
        default:   ;
      endcase
    end
  end

  // Configuration registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_q <= 32'h0000_0F03; value_q <= 32'h0; dp_q <= 32'h0; blank_q <= 32'h0;
      raw0_q <= 32'h0; raw1_q <= 32'h0; div_q <= {16'h0, DEFAULT_DIV};
    end else begin
      ctrl_q <= ctrl_d; value_q <= value_d; dp_q <= dp_d; blank_q <= blank_d;
      raw0_q <= raw0_d; raw1_q <= raw1_d; div_q <= div_d;
    end
  end

  // Next-state enable and slot length, so a write on a reload edge is honoured there.
  assign en_q   = ctrl_q[0];
  assign en_d   = ctrl_d[0];
  assign reload = (div_d[15:0] == 16'd0) ? 16'd1 : div_d[15:0];

  // Scan engine: prescaler, digit index, frame count and free-running PWM.
  // The enable edge itself is spent parked, so a re-enabled scan gets a full slot.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      presc_q <= RESET_PRESC; idx_q <= 3'd0; first_q <= 1'b1;
      frame_q <= 8'd0; pwm_q <= 4'd0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
      if (!en_d || !en_q) begin
        presc_q <= reload; idx_q <= 3'd0; first_q <= 1'b1;
      end else if (presc_q == 16'd0) begin
        presc_q <= reload;
        first_q <= 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_q   <= 3'd0;
          frame_q <= frame_q + 8'd1;
        end else begin
          idx_q <= idx_q + 3'd1;
        end
      end else begin
        presc_q <= presc_q - 16'd1;
        first_q <= 1'b0;
      end
    end
  end

  // Content and select of the digit being scanned; the slot's first cycle is dead.
  always_comb begin
    nib      = value_q[{idx_q, 2'b00} +: 4];
    raw_byte = idx_q[2] ? raw1_q[{idx_q[1:0], 3'b000} +: 8]
                        : raw0_q[{idx_q[1:0], 3'b000} +: 8];
    if (blank_q[idx_q])  digit_seg = 8'h00;
    else if (ctrl_q[1])  digit_seg = {dp_q[idx_q], hex7(nib)};
    else                 digit_seg = raw_byte;
    sel_on = !first_q && (pwm_q <= ctrl_q[11:8]);
    for (int k = 0; k < NUM_DIGITS; k++) cs_hot[k] = sel_on && (idx_q == 3'(k));
  end

  // Registered pin drivers with polarity applied; blanked while disabled.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      seg_q <= SEG_OFF; segcs_q <= CS_OFF;
    end else if (!en_d) begin
      seg_q <= SEG_OFF; segcs_q <= CS_OFF;
    end else begin
      seg_q   <= digit_seg ^ SEG_OFF;
      segcs_q <= cs_hot ^ CS_OFF;
    end
  end

  // Read mux for the registered data-phase offset.
  always_comb begin
    rdata = 32'h0;
    case (addr_q)
      OFF_CTRL:   rdata = ctrl_q;
      OFF_VALUE:  rdata = value_q;
      OFF_DP:     rdata = dp_q;
      OFF_BLANK:  rdata = blank_q;
      OFF_RAW0:   rdata = raw0_q;
      OFF_RAW1:   rdata = raw1_q;
      OFF_DIV:    rdata = div_q;
      OFF_STATUS: rdata = {16'h0, frame_q, 5'h0, idx_q};
      default:    rdata = 32'h0;
    endcase
  end

  assign HRDATA    = (valid_q && !wr_q) ? rdata : 32'h0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign SEG       = seg_q;
  assign SEGCS     = segcs_q;

endmodule

// File: tb/tb_ahb_seg_scanner.sv
// Bench for ahb_seg_scanner: directed steps plus randomized display
// configurations, checked against an arithmetic model of the scan timing.
module tb_ahb_seg_scanner;

  localparam int N = 4;

  // Clock / reset
  logic hclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 hclk = ~hclk;

  logic        hsel, hwrite, hready, hreadyout, hresp;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [7:0]  seg;
  logic [N-1:0] segcs;

  ahb_seg_scanner #(
    .NUM_DIGITS(N), .DEFAULT_DIV(16'd3), .SEG_ACTIVE_LOW(1'b1), .CS_ACTIVE_LOW(1'b1)
  ) dut (
    .HCLK(hclk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HPROT(hprot), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata), .SEG(seg), .SEGCS(segcs)
  );

  // Clock edges since reset release; the PWM phase follows it directly.
  int cyc;
  always @(posedge hclk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] hex_tbl [0:15] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Shadow of the programmed registers (reference model state).
  logic [31:0] s_ctrl, s_value, s_dp, s_blank, s_raw0, s_raw1, s_div;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Driver tasks: all called at a negedge, all return at a negedge.
  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
  endtask

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d, input logic [2:0] sz);
    hsel = 1'b1; htrans = 2'b10; haddr = {24'h0, a}; hwrite = 1'b1; hsize = sz;
    @(negedge hclk);
    bus_idle();
    hwdata = d;
    @(negedge hclk);
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; haddr = {24'h0, a}; hwrite = 1'b0; hsize = 3'b010;
    @(negedge hclk);
    d = hrdata;
    bus_idle();
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    ahb_read(a, v);
    check(tag, v, exp);
  endtask

  // Full-word write that also updates the model, masked to what exists for 4 digits.
  task automatic cfg(input logic [7:0] a, input logic [31:0] d);
    ahb_write(a, d, 3'b010);
    case (a)
      8'h00: s_ctrl  = d & 32'h0000_0F03;
      8'h04: s_value = d & 32'h0000_FFFF;
      8'h08: s_dp    = d & 32'h0000_000F;
      8'h0C: s_blank = d & 32'h0000_000F;
      8'h10: s_raw0  = d;
      8'h14: s_raw1  = 32'h0;
      8'h20: s_div   = d & 32'h0000_FFFF;
      default: ;
    endcase
  endtask

  // Active-high segment byte digit k should show.
  function automatic logic [7:0] exp_content(input int k);
    logic [3:0] nib;
    logic [7:0] raw;
    nib = 4'((s_value >> (4 * k)) & 32'hF);
    raw = 8'(((k < 4) ? s_raw0 : s_raw1) >> (8 * (k % 4)));
    if (s_blank[k]) return 8'h00;
    if (s_ctrl[1])  return {s_dp[k], hex_tbl[nib][6:0]};
    return raw;
  endfunction

  // Slot number and position within the slot, c cycles after the scan started.
  function automatic void slot_of(input int c, input int len0, input int len,
                                  output int s, output int pos);
    if (c < len0) begin s = 0; pos = c; end
    else begin s = 1 + (c - len0) / len; pos = (c - len0) % len; end
  endfunction

  // Scoreboard over n cycles of a scan that started (state cycle 0) at edge count c0.
  task automatic run_window(input int n, input int len0, input int len, input int c0,
                            input bit chk_status);
    int s, pos, k, d;
    bit act;
    logic [3:0]  exp_cs;
    logic [31:0] exp_st;
    for (int i = 0; i < n; i++) begin
      if (chk_status) begin
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h24; hwrite = 1'b0;
      end
      @(negedge hclk);
      k = cyc;
      slot_of(k - 1 - c0, len0, len, s, pos);
      d = s % N;
      act = (pos != 0) && (((k - 1) % 16) <= int'(s_ctrl[11:8]));
      exp_cs = act ? ~(4'b0001 << d) : 4'hF;
      check("segcs", {28'h0, segcs}, {28'h0, exp_cs});
      if (act) check("seg", {24'h0, seg}, {24'h0, ~exp_content(d)});
      if (chk_status) begin
        slot_of(k - c0, len0, len, s, pos);
        exp_st = {16'h0, 8'(s / N), 5'h0, 3'(s % N)};
        check("status", hrdata, exp_st);
      end
    end
    bus_idle();
  endtask

  task automatic check_dark(input string tag);
    check(tag, {20'h0, segcs, seg}, {20'h0, 4'hF, 8'hFF});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  int c0, eff;
  logic [31:0] v;
  logic [3:0]  br;
  logic        hx;

  initial begin
    bus_idle();
    hready = 1'b1; hprot = 4'h0; haddr = 32'h0; hwdata = 32'h0;
    s_ctrl = 32'h0F03; s_value = 0; s_dp = 0; s_blank = 0; s_raw0 = 0; s_raw1 = 0; s_div = 3;
    repeat (3) @(negedge hclk);
    rst_n = 1'b1;

    // Reset state, then SCAN_DIV 3 -> 7 written inside the first slot.
    check("rst_segcs", {28'h0, segcs}, 32'hF);
    check("rst_seg", {24'h0, seg}, 32'hFF);
    check("rst_hrdata", hrdata, 32'h0);
    check("hreadyout", {31'h0, hreadyout}, 32'h1);
    check("hresp", {31'h0, hresp}, 32'h0);
    cfg(8'h20, 32'd7);
    run_window(80, 4, 8, 0, 1'b1);

    // Digits of 0x1234 with a 4-cycle slot.
    cfg(8'h00, 32'h0F02);
    check_dark("disabled_out");
    cfg(8'h20, 32'd3);
    cfg(8'h04, 32'h1234);
    cfg(8'h00, 32'h0F03);
    c0 = cyc;
    run_window(20, 4, 4, c0, 1'b0);

    // Clear enable while digit 2 is mid-slot.
    while (((cyc - c0) % 16) != 8) @(negedge hclk);
    cfg(8'h00, 32'h0F02);
    check_dark("disable_mid_slot");
    ahb_read(8'h24, v);
    check("status_idx_off", {29'h0, v[2:0]}, 32'h0);
    repeat (6) begin
      @(negedge hclk);
      check_dark("held_off");
    end
    cfg(8'h00, 32'h0F03);
    c0 = cyc;
    run_window(12, 4, 4, c0, 1'b0);

    // Brightness 3 with 32-cycle slots.
    cfg(8'h00, 32'h0302);
    cfg(8'h20, 32'd31);
    cfg(8'h00, 32'h0303);
    c0 = cyc;
    run_window(70, 32, 32, c0, 1'b0);

    // Raw mode: byte and halfword lane writes.
    cfg(8'h00, 32'h0F00);
    cfg(8'h20, 32'd3);
    cfg(8'h10, 32'h0);
    ahb_write(8'h11, 32'h0000_5500, 3'b000);
    s_raw0 = 32'h0000_5500;
    rd_check("raw0_byte", 8'h10, 32'h0000_5500);
    cfg(8'h00, 32'h0F01);
    c0 = cyc;
    run_window(12, 4, 4, c0, 1'b0);
    cfg(8'h00, 32'h0F00);
    ahb_write(8'h12, 32'hABCD_0000, 3'b001);
    s_raw0 = 32'hABCD_5500;
    rd_check("raw0_half", 8'h10, 32'hABCD_5500);

    // Register-file corner cases (display disabled).
    begin
      logic [31:0] r;
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h08; hwrite = 1'b1; hsize = 3'b010;
      @(negedge hclk);
      haddr = 32'h08; hwrite = 1'b0; hwdata = 32'h5;
      @(negedge hclk);
      r = hrdata;
      bus_idle();
      s_dp = 32'h5;
      check("dp_b2b", r, 32'h5);
    end
    rd_check("unmapped_3c", 8'h3C, 32'h0);
    ahb_write(8'h24, 32'hFFFF_FFFF, 3'b010);
    ahb_read(8'h24, v);
    check("status_ro", v & 32'hFFFF_00FF, 32'h0);
    cfg(8'h04, 32'hFFFF_FFFF);
    rd_check("value_mask", 8'h04, 32'h0000_FFFF);
    cfg(8'h0C, 32'hFFFF_FFFF);
    rd_check("blank_mask", 8'h0C, 32'h0000_000F);
    cfg(8'h14, 32'hFFFF_FFFF);
    rd_check("raw1_absent", 8'h14, 32'h0);
    ahb_write(8'h00, 32'hFFFF_FFFE, 3'b010);
    s_ctrl = 32'h0F02;
    rd_check("ctrl_mask", 8'h00, 32'h0000_0F02);
    hready = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h08; hwrite = 1'b1;
    @(negedge hclk);
    hready = 1'b1;
    bus_idle();
    hwdata = 32'hA;
    @(negedge hclk);
    rd_check("hready_low_ignored", 8'h08, 32'h5);

    // Randomized configurations, each from a fresh enable.
    for (int it = 0; it < 8; it++) begin
      br = 4'($urandom_range(0, 15));
      hx = 1'($urandom_range(0, 1));
      cfg(8'h00, {20'h0, br, 6'h0, hx, 1'b0});
      cfg(8'h20, $urandom_range(0, 5));
      cfg(8'h04, $urandom);
      cfg(8'h08, $urandom);
      cfg(8'h0C, $urandom_range(0, 3) == 0 ? $urandom : 32'h0);
      cfg(8'h10, $urandom);
      cfg(8'h00, {20'h0, br, 6'h0, hx, 1'b1});
      c0 = cyc;
      eff = (s_div == 0) ? 1 : int'(s_div);
      run_window(2 * N * (eff + 1) + 3, eff + 1, eff + 1, c0, 1'b0);
    end

    // Asynchronous reset in the middle of a read data phase and a slot.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h00; hwrite = 1'b0;
    @(posedge hclk);
    #2;
    check("pre_reset_read", hrdata, s_ctrl);
    rst_n = 1'b0;
    #1;
    check("async_rst_hrdata", hrdata, 32'h0);
    check_dark("async_rst_out");
    bus_idle();
    @(negedge hclk);
    @(negedge hclk);
    rst_n = 1'b1;
    s_ctrl = 32'h0F03; s_value = 0; s_dp = 0; s_blank = 0; s_raw0 = 0; s_div = 3;
    rd_check("rst_ctrl", 8'h00, 32'h0000_0F03);
    rd_check("rst_div", 8'h20, 32'h0000_0003);
    rd_check("rst_value", 8'h04, 32'h0);
    rd_check("rst_dp", 8'h08, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
